// File: rtl/log2_share_arbiter.sv
// Round-robin front end that time-shares one fixed-latency log2 pipeline
// between NUM_REQ requesters, steering results back through a one-entry output register.
module log2_share_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned PIPE_LAT = 3,
  parameter int unsigned DATA_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_in0,
  input  logic [NUM_REQ*DATA_W-1:0] req_in1,
  output logic                      pipe_en,
  output logic                      pipe_valid_in,
  output logic [DATA_W-1:0]         pipe_in_0,
  output logic [DATA_W-1:0]         pipe_in_1,
  input  logic                      pipe_valid_out,
  input  logic [DATA_W-1:0]         pipe_log,
  input  logic [DATA_W-1:0]         pipe_in_0_bypass,
  input  logic [DATA_W-1:0]         pipe_in_1_bypass,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_log,
  output logic [DATA_W-1:0]         rsp_in0,
  output logic [DATA_W-1:0]         rsp_in1,
  output logic                      busy
);

  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [DATA_W-1:0] in0_arr [NUM_REQ];
  logic [DATA_W-1:0] in1_arr [NUM_REQ];

  logic [ID_W-1:0]     rr_ptr;
  logic                grant_found;
  logic [ID_W-1:0]     grant_id;
  logic [ID_W:0]       cand;
  logic                issue;

  logic [PIPE_LAT-1:0] tag_vld;
  logic [ID_W-1:0]     tag_id [PIPE_LAT];

  logic                out_valid;
  logic [ID_W-1:0]     out_tag;
  logic                out_accept;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign in0_arr[g] = req_in0[g*DATA_W +: DATA_W];
    assign in1_arr[g] = req_in1[g*DATA_W +: DATA_W];
  end

  // Stall the whole pipeline while a held result is not being taken.
  assign out_accept = out_valid && rsp_ready[out_tag];
  assign pipe_en    = !out_valid || out_accept;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_found && req_valid[ID_W'(cand)]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(cand);
      end
    end
  end

  assign issue         = grant_found && pipe_en && !rst;
  assign req_ready     = issue ? (NUM_REQ'(1) << grant_id) : '0;
  assign pipe_valid_in = issue;
  assign pipe_in_0     = issue ? in0_arr[grant_id] : '0;
  assign pipe_in_1     = issue ? in1_arr[grant_id] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);
    end
  end

  // Owner tags travel alongside the stage so results find their requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        tag_id[i] <= '0;
      end
    end else if (pipe_en) begin
      tag_vld[0] <= issue;
      tag_id[0]  <= grant_id;
      for (int i = 1; i < PIPE_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  // A fresh capture wins over an accept in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      rsp_log   <= '0;
      rsp_in0   <= '0;
      rsp_in1   <= '0;
    end else if (pipe_en && pipe_valid_out) begin
      out_valid <= 1'b1;
      out_tag   <= tag_id[PIPE_LAT-1];
      rsp_log   <= pipe_log;
      rsp_in0   <= pipe_in_0_bypass;
      rsp_in1   <= pipe_in_1_bypass;
    end else if (out_accept) begin
      out_valid <= 1'b0;
    end
  end

  assign rsp_valid = out_valid ? (NUM_REQ'(1) << out_tag) : '0;
  assign busy      = out_valid || (|tag_vld);

endmodule

// File: tb/tb_log2_share_arbiter.sv
// Directed bench for log2_share_arbiter with a behavioural three-stage log2 stage attached.
module tb_log2_share_arbiter;

  localparam int N = 4;
  localparam int L = 3;
  localparam int W = 16;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_in0;
  logic [N*W-1:0] req_in1;
  logic           pipe_en;
  logic           pipe_valid_in;
  logic [W-1:0]   pipe_in_0;
  logic [W-1:0]   pipe_in_1;
  logic           pipe_valid_out;
  logic [W-1:0]   pipe_log;
  logic [W-1:0]   pipe_in_0_bypass;
  logic [W-1:0]   pipe_in_1_bypass;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [W-1:0]   rsp_log;
  logic [W-1:0]   rsp_in0;
  logic [W-1:0]   rsp_in1;
  logic           busy;

  int checks = 0;
  int errors = 0;
  int align_err = 0;

  log2_share_arbiter #(.NUM_REQ(N), .PIPE_LAT(L), .DATA_W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in0(req_in0), .req_in1(req_in1),
    .pipe_en(pipe_en), .pipe_valid_in(pipe_valid_in),
    .pipe_in_0(pipe_in_0), .pipe_in_1(pipe_in_1),
    .pipe_valid_out(pipe_valid_out), .pipe_log(pipe_log),
    .pipe_in_0_bypass(pipe_in_0_bypass), .pipe_in_1_bypass(pipe_in_1_bypass),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_log(rsp_log), .rsp_in0(rsp_in0), .rsp_in1(rsp_in1),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Q6.10 log2: exact integer part, linear mantissa for the fraction.
  function automatic logic [15:0] log2_q(input logic [15:0] x);
    int p;
    logic [31:0] f;
    p = -1;
    for (int i = 0; i < 16; i++) if (x[i]) p = i;
    if (p < 0) return 16'h0000;
    f = (32'(x) << (15 - p)) & 32'h7FFF;
    return 16'((p - 10) * 1024) + 16'(f >> 5);
  endfunction

  logic [L-1:0] m_vld;
  logic [W-1:0] m_log [L];
  logic [W-1:0] m_b0  [L];
  logic [W-1:0] m_b1  [L];

  always_ff @(posedge clk) begin
    if (rst) begin
      m_vld <= '0;
    end else if (pipe_en) begin
      m_vld[0] <= pipe_valid_in;
      m_log[0] <= log2_q(pipe_in_0);
      m_b0[0]  <= pipe_in_0;
      m_b1[0]  <= pipe_in_1;
      for (int i = 1; i < L; i++) begin
        m_vld[i] <= m_vld[i-1];
        m_log[i] <= m_log[i-1];
        m_b0[i]  <= m_b0[i-1];
        m_b1[i]  <= m_b1[i-1];
      end
    end
  end

  assign pipe_valid_out   = m_vld[L-1];
  assign pipe_log         = m_log[L-1];
  assign pipe_in_0_bypass = m_b0[L-1];
  assign pipe_in_1_bypass = m_b1[L-1];

  always @(negedge clk) begin
    if (!rst && (pipe_valid_out !== dut.tag_vld[L-1])) align_err++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_in0[i*W +: W] = a;
    req_in1[i*W +: W] = b;
  endtask

  task automatic reset_dut();
    tick();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = '1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    rst = 1'b1;
    req_valid = 4'hF;
    rsp_ready = 4'hF;
    for (int i = 0; i < N; i++) set_op(i, 16'h1111, 16'h2222);
    tick();
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
    checks++; if (pipe_valid_in !== 1'b0) begin errors++; $display("FAIL reset_pipe_valid_in: got %b expected 0", pipe_valid_in); end
    checks++; if (pipe_in_0 !== 16'h0) begin errors++; $display("FAIL reset_pipe_in_0: got %h expected 0000", pipe_in_0); end
    checks++; if (pipe_in_1 !== 16'h0) begin errors++; $display("FAIL reset_pipe_in_1: got %h expected 0000", pipe_in_1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (pipe_en !== 1'b1) begin errors++; $display("FAIL reset_pipe_en: got %b expected 1", pipe_en); end
    checks++; if (rsp_log !== 16'h0) begin errors++; $display("FAIL reset_rsp_log: got %h expected 0000", rsp_log); end
    checks++; if (rsp_in0 !== 16'h0) begin errors++; $display("FAIL reset_rsp_in0: got %h expected 0000", rsp_in0); end
    rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single();
    reset_dut();
    set_op(0, 16'h0400, 16'h1234);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", req_ready); end
    checks++; if (pipe_valid_in !== 1'b1) begin errors++; $display("FAIL single_pipe_valid_in: got %b expected 1", pipe_valid_in); end
    checks++; if (pipe_in_0 !== 16'h0400) begin errors++; $display("FAIL single_pipe_in_0: got %h expected 0400", pipe_in_0); end
    checks++; if (pipe_in_1 !== 16'h1234) begin errors++; $display("FAIL single_pipe_in_1: got %h expected 1234", pipe_in_1); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_early1: got %b expected 0000", rsp_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    tick();
    tick();
    checks++; if (pipe_valid_out !== 1'b1) begin errors++; $display("FAIL single_pipe_valid_out: got %b expected 1", pipe_valid_out); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_early3: got %b expected 0000", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid: got %b expected 0001", rsp_valid); end
    checks++; if (rsp_log !== 16'h0000) begin errors++; $display("FAIL single_rsp_log: got %h expected 0000", rsp_log); end
    checks++; if (rsp_in0 !== 16'h0400) begin errors++; $display("FAIL single_rsp_in0: got %h expected 0400", rsp_in0); end
    checks++; if (rsp_in1 !== 16'h1234) begin errors++; $display("FAIL single_rsp_in1: got %h expected 1234", rsp_in1); end
    tick();
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_drained: got %b expected 0000", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_round_robin();
    int exp_g[5] = '{0, 1, 2, 3, 0};
    reset_dut();
    for (int i = 0; i < N; i++) set_op(i, 16'h0800, 16'(16'h0010 + i));
    for (int c = 0; c < 9; c++) begin
      req_valid = (c < 5) ? 4'hF : 4'h0;
      #1;
      if (c < 5) begin
        checks++; if (req_ready !== 4'(1 << exp_g[c])) begin errors++; $display("FAIL rr_grant c=%0d: got %b expected %b", c, req_ready, 4'(1 << exp_g[c])); end
      end
      checks++; if (pipe_en !== 1'b1) begin errors++; $display("FAIL rr_pipe_en c=%0d: got %b expected 1", c, pipe_en); end
      if (c >= 4) begin
        checks++; if (rsp_valid !== 4'(1 << exp_g[c-4])) begin errors++; $display("FAIL rr_rsp_valid c=%0d: got %b expected %b", c, rsp_valid, 4'(1 << exp_g[c-4])); end
        checks++; if (rsp_log !== 16'h0400) begin errors++; $display("FAIL rr_rsp_log c=%0d: got %h expected 0400", c, rsp_log); end
        checks++; if (rsp_in1 !== 16'(16'h0010 + exp_g[c-4])) begin errors++; $display("FAIL rr_rsp_in1 c=%0d: got %h expected %h", c, rsp_in1, 16'(16'h0010 + exp_g[c-4])); end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    for (int c = 0; c < 9; c++) begin
      set_op(1, 16'h0400, 16'(16'h0B00 + c));
      req_valid = (c < 4) ? 4'b0010 : 4'b0000;
      #1;
      checks++; if (pipe_en !== 1'b1) begin errors++; $display("FAIL b2b_pipe_en c=%0d: got %b expected 1", c, pipe_en); end
      if (c >= 4 && c < 8) begin
        checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL b2b_rsp_valid c=%0d: got %b expected 0010", c, rsp_valid); end
        checks++; if (rsp_in1 !== 16'(16'h0B00 + c - 4)) begin errors++; $display("FAIL b2b_rsp_in1 c=%0d: got %h expected %h", c, rsp_in1, 16'(16'h0B00 + c - 4)); end
      end
      if (c == 8) begin
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL b2b_end: got %b expected 0000", rsp_valid); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    rsp_ready = 4'b1011;
    for (int c = 0; c < 14; c++) begin
      set_op(2, 16'h0100, 16'(16'h00A0 + c));
      req_valid = (c < 9) ? 4'b0100 : 4'b0000;
      if (c >= 9) rsp_ready = 4'hF;
      #1;
      if (c < 4) begin
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant c=%0d: got %b expected 0100", c, req_ready); end
      end else if (c < 9) begin
        checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL bp_hold_valid c=%0d: got %b expected 0100", c, rsp_valid); end
        checks++; if (rsp_log !== 16'hF800) begin errors++; $display("FAIL bp_hold_log c=%0d: got %h expected F800", c, rsp_log); end
        checks++; if (rsp_in1 !== 16'h00A0) begin errors++; $display("FAIL bp_hold_in1 c=%0d: got %h expected 00A0", c, rsp_in1); end
        checks++; if (pipe_en !== 1'b0) begin errors++; $display("FAIL bp_pipe_en c=%0d: got %b expected 0", c, pipe_en); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_req_ready c=%0d: got %b expected 0000", c, req_ready); end
      end else if (c < 13) begin
        checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL bp_drain_valid c=%0d: got %b expected 0100", c, rsp_valid); end
        checks++; if (rsp_in1 !== 16'(16'h00A0 + c - 9)) begin errors++; $display("FAIL bp_drain_in1 c=%0d: got %h expected %h", c, rsp_in1, 16'(16'h00A0 + c - 9)); end
        checks++; if (rsp_log !== 16'hF800) begin errors++; $display("FAIL bp_drain_log c=%0d: got %h expected F800", c, rsp_log); end
        checks++; if (pipe_en !== 1'b1) begin errors++; $display("FAIL bp_release_en c=%0d: got %b expected 1", c, pipe_en); end
      end else begin
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL bp_empty: got %b expected 0000", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy: got %b expected 0", busy); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    for (int i = 0; i < N; i++) set_op(i, 16'h0800, 16'(i));
    for (int c = 0; c < 3; c++) begin
      req_valid = 4'hF;
      #1;
      checks++; if (req_ready !== 4'(1 << c)) begin errors++; $display("FAIL rm_grant c=%0d: got %b expected %b", c, req_ready, 4'(1 << c)); end
      tick();
    end
    req_valid = '0;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy_before: got %b expected 1", busy); end
    tick();
    rst = 1'b0;
    for (int c = 4; c < 10; c++) begin
      #1;
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rm_rsp_valid c=%0d: got %b expected 0000", c, rsp_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy c=%0d: got %b expected 0", c, busy); end
      tick();
    end
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_next_grant: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0;
  endtask

  task automatic test_idle_gaps();
    logic [3:0]  v[14] = '{4'h8, 4'h0, 4'h0, 4'h8, 4'h0, 4'hA, 4'hA, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
    int          g[14] = '{3, -1, -1, 3, -1, 1, 3, -1, -1, 3, -1, -1, -1, -1};
    logic [15:0] a;
    reset_dut();
    for (int c = 0; c < 14; c++) begin
      a = (c == 9) ? 16'h0000 : 16'h0800;
      set_op(1, a, 16'(16'h0300 + c));
      set_op(3, a, 16'(16'h0300 + c));
      req_valid = v[c];
      #1;
      if (g[c] >= 0) begin
        checks++; if (req_ready !== 4'(1 << g[c])) begin errors++; $display("FAIL idle_grant c=%0d: got %b expected %b", c, req_ready, 4'(1 << g[c])); end
        checks++; if (pipe_in_0 !== a) begin errors++; $display("FAIL idle_pipe_in_0 c=%0d: got %h expected %h", c, pipe_in_0, a); end
        checks++; if (pipe_in_1 !== 16'(16'h0300 + c)) begin errors++; $display("FAIL idle_pipe_in_1 c=%0d: got %h expected %h", c, pipe_in_1, 16'(16'h0300 + c)); end
      end else begin
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL idle_no_grant c=%0d: got %b expected 0000", c, req_ready); end
        checks++; if (pipe_in_0 !== 16'h0000) begin errors++; $display("FAIL idle_zero_in_0 c=%0d: got %h expected 0000", c, pipe_in_0); end
        checks++; if (pipe_valid_in !== 1'b0) begin errors++; $display("FAIL idle_valid_in c=%0d: got %b expected 0", c, pipe_valid_in); end
      end
      if (c >= 4 && g[c-4] >= 0) begin
        checks++; if (rsp_valid !== 4'(1 << g[c-4])) begin errors++; $display("FAIL idle_rsp_valid c=%0d: got %b expected %b", c, rsp_valid, 4'(1 << g[c-4])); end
        checks++; if (rsp_in1 !== 16'(16'h0300 + c - 4)) begin errors++; $display("FAIL idle_rsp_in1 c=%0d: got %h expected %h", c, rsp_in1, 16'(16'h0300 + c - 4)); end
      end else begin
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL idle_rsp_none c=%0d: got %b expected 0000", c, rsp_valid); end
      end
      tick();
    end
  endtask

  task automatic test_alignment();
    checks++; if (align_err !== 0) begin errors++; $display("FAIL tag_alignment: got %0d misaligned cycles expected 0", align_err); end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = '1;
    req_in0 = '0;
    req_in1 = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_idle_gaps();
    test_alignment();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
